// File: rtl/dmem_responder_pkg.sv
// rtl/dmem_responder_pkg.sv - shared types and constants for the data-memory responder
package dmem_responder_pkg;

  localparam int   RegBus       = 32;
  localparam int   DmemSelBus   = 4;
  localparam logic RstActiveLow = 1'b0;
  localparam logic True_v       = 1'b1;
  localparam logic False_v      = 1'b0;

  typedef enum logic [1:0] {
    DmemIdle = 2'd0,
    DmemWait = 2'd1,
    DmemAck  = 2'd2
  } dmem_state_e;

  // Expand per-lane enables into a 32-bit bit mask
  function automatic logic [RegBus-1:0] lane_mask(input logic [DmemSelBus-1:0] sel);
    logic [RegBus-1:0] m;
    m = '0;
    for (int i = 0; i < DmemSelBus; i++) begin
      m[8*i +: 8] = {8{sel[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - MEM-stage request/acknowledge bundle
interface dmem_responder_if;
  import dmem_responder_pkg::*;

  logic                  mem_req;
  logic                  mem_we;
  logic [RegBus-1:0]     mem_addr;
  logic [DmemSelBus-1:0] mem_sel;
  logic [RegBus-1:0]     mem_wdata;
  logic                  ack;
  logic                  err;
  logic [RegBus-1:0]     rdata;
  logic                  stall_req;

  modport master (
    output mem_req, mem_we, mem_addr, mem_sel, mem_wdata,
    input  ack, err, rdata, stall_req
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_sel, mem_wdata,
    output ack, err, rdata, stall_req
  );

endinterface

// File: rtl/dmem_responder_ram.sv
// rtl/dmem_responder_ram.sv - single-port byte-enabled word RAM, read-first
module dmem_ram #(
  parameter int DEPTH = 1024,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [3:0]    be,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rd_q;

  // Read returns the word as it was before any write on the same edge
  always_ff @(posedge clk) begin
    if (en) begin
      rd_q <= mem_q[addr];
      if (we) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  assign rdata = rd_q;

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - wait-stated load/store responder for the MEM stage
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input logic             clk,
  input logic             rst,
  dmem_responder_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CntLoad = CW'(WAIT_CYCLES);

  dmem_state_e           state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [AW-1:0]         idx_q, idx_d;
  logic [DmemSelBus-1:0] sel_q, sel_d;
  logic [RegBus-1:0]     wdata_q, wdata_d;
  logic                  bad_q, bad_d;
  logic                  ack_q, ack_d;
  logic                  err_q, err_d;
  logic [RegBus-1:0]     rmask_q, rmask_d;

  logic              ram_en;
  logic              ram_we;
  logic [RegBus-1:0] ram_rdata;
  logic              unused_addr_lsb;

  assign unused_addr_lsb = ^bus.mem_addr[1:0];

  // Next-state, request latching and access strobes
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    idx_d   = idx_q;
    sel_d   = sel_q;
    wdata_d = wdata_q;
    bad_d   = bad_q;
    ack_d   = False_v;
    err_d   = err_q;
    rmask_d = rmask_q;
    ram_en  = 1'b0;
    ram_we  = 1'b0;
    case (state_q)
      DmemIdle: begin
        if (bus.mem_req) begin
          we_d    = bus.mem_we;
          idx_d   = bus.mem_addr[AW+1:2];
          sel_d   = bus.mem_sel;
          wdata_d = bus.mem_wdata;
          bad_d   = (bus.mem_sel == '0) || (bus.mem_addr[31:2] >= 30'(DEPTH));
          cnt_d   = CntLoad;
          state_d = DmemWait;
        end
      end
      DmemWait: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = DmemAck;
          ack_d   = True_v;
          err_d   = bad_q;
          // Rejected requests never touch the RAM; stores and rejects return zero
          ram_en  = ~bad_q;
          ram_we  = ~bad_q & we_q & (rst != RstActiveLow);
          rmask_d = (bad_q | we_q) ? '0 : lane_mask(sel_q);
        end
      end
      DmemAck: state_d = DmemIdle;
      default: state_d = DmemIdle;
    endcase
  end

  // All control and output registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstActiveLow) begin
      state_q <= DmemIdle;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      sel_q   <= '0;
      wdata_q <= '0;
      bad_q   <= 1'b0;
      ack_q   <= False_v;
      err_q   <= False_v;
      rmask_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      sel_q   <= sel_d;
      wdata_q <= wdata_d;
      bad_q   <= bad_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rmask_q <= rmask_d;
    end
  end

  dmem_ram #(.DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (idx_q),
    .be    (sel_q),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  // The RAM output only changes on an access edge, so masking it with the
  // registered lane mask yields a held, reset-clean load result
  assign bus.rdata     = ram_rdata & rmask_q;
  assign bus.ack       = ack_q;
  assign bus.err       = err_q;
  assign bus.stall_req = bus.mem_req & ~ack_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - randomized self-checking bench for dmem_responder
module tb_dmem_responder;

  localparam int NDUT = 4;

  logic clk;
  logic rst;

  logic        req   [NDUT];
  logic        we_v  [NDUT];
  logic [31:0] addr_v[NDUT];
  logic [3:0]  sel_v [NDUT];
  logic [31:0] wd_v  [NDUT];
  logic        ack_o [NDUT];
  logic        err_o [NDUT];
  logic        stall_o[NDUT];
  logic [31:0] rd_o  [NDUT];

  int checks = 0;
  int fails  = 0;

  logic [31:0] mdl [NDUT][1024];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int W = (g == 0) ? 1 : (g == 1) ? 3 : (g == 2) ? 0 : 5;
    dmem_responder_if ifc ();
    assign ifc.mem_req   = req[g];
    assign ifc.mem_we    = we_v[g];
    assign ifc.mem_addr  = addr_v[g];
    assign ifc.mem_sel   = sel_v[g];
    assign ifc.mem_wdata = wd_v[g];
    assign ack_o[g]      = ifc.ack;
    assign err_o[g]      = ifc.err;
    assign stall_o[g]    = ifc.stall_req;
    assign rd_o[g]       = ifc.rdata;
    dmem_responder #(.DEPTH(1024), .WAIT_CYCLES(W)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc.slave)
    );
  end

  function automatic int wc(input int k);
    return (k == 0) ? 1 : (k == 1) ? 3 : (k == 2) ? 0 : 5;
  endfunction

  // Reference memory: word array with lane-granular writes
  task automatic model_op(input int k, input logic we, input logic [31:0] addr,
                          input logic [3:0] sel, input logic [31:0] wd,
                          output logic [31:0] exp_rd, output logic exp_err);
    int idx;
    idx     = int'(addr[11:2]);
    exp_err = (sel == 4'b0000) || (addr[31:2] >= 30'd1024);
    exp_rd  = 32'h0;
    if (!exp_err) begin
      for (int i = 0; i < 4; i++) begin
        if (sel[i] && we)  mdl[k][idx][8*i +: 8] = wd[8*i +: 8];
        if (sel[i] && !we) exp_rd[8*i +: 8] = mdl[k][idx][8*i +: 8];
      end
    end
  endtask

  // One full transaction; fields are scrambled after sampling to prove they are latched
  task automatic access(input int k, input logic we, input logic [31:0] addr,
                        input logic [3:0] sel, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat);
    @(negedge clk);
    req[k] = 1'b1; we_v[k] = we; addr_v[k] = addr; sel_v[k] = sel; wd_v[k] = wd;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    addr_v[k] = $urandom; wd_v[k] = $urandom; sel_v[k] = 4'($urandom); we_v[k] = 1'($urandom);
    while (ack_o[k] !== 1'b1 && lat < 40) begin
      checks++;
      if (stall_o[k] !== 1'b1) begin
        fails++; $display("FAIL stall_wait dut%0d: got %b want 1", k, stall_o[k]);
      end
      @(posedge clk); lat++; @(negedge clk);
    end
    checks++;
    if (ack_o[k] !== 1'b1) begin
      fails++; $display("FAIL ack_timeout dut%0d: no ack after %0d cycles", k, lat);
    end
    checks++;
    if (stall_o[k] !== 1'b0) begin
      fails++; $display("FAIL stall_ack dut%0d: got %b want 0", k, stall_o[k]);
    end
    rd = rd_o[k]; er = err_o[k];
    req[k] = 1'b0;
    @(negedge clk);
    checks++;
    if (ack_o[k] !== 1'b0 || rd_o[k] !== rd || err_o[k] !== er) begin
      fails++;
      $display("FAIL ack_hold dut%0d: ack=%b rdata=%h err=%b want ack=0 rdata=%h err=%b",
               k, ack_o[k], rd_o[k], err_o[k], rd, er);
    end
  endtask

  task automatic run_op(input int k, input logic we, input logic [31:0] addr,
                        input logic [3:0] sel, input logic [31:0] wd, input string name);
    logic [31:0] rd, erd;
    logic er, eer;
    int lat;
    access(k, we, addr, sel, wd, rd, er, lat);
    model_op(k, we, addr, sel, wd, erd, eer);
    checks++;
    if (lat != wc(k) + 2) begin
      fails++; $display("FAIL %s_latency dut%0d: got %0d want %0d", name, k, lat, wc(k) + 2);
    end
    checks++;
    if (er !== eer) begin
      fails++; $display("FAIL %s_err dut%0d: got %b want %b", name, k, er, eer);
    end
    if (!we || eer) begin
      checks++;
      if (rd !== erd) begin
        fails++; $display("FAIL %s_rdata dut%0d addr=%h sel=%b: got %h want %h",
                          name, k, addr, sel, rd, erd);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int k = 0; k < NDUT; k++) begin
      req[k] = 1'b0; we_v[k] = 1'b0; addr_v[k] = '0; sel_v[k] = '0; wd_v[k] = '0;
    end
    #1 rst = 1'b0;
    #1;
    for (int k = 0; k < NDUT; k++) begin
      checks++;
      if (ack_o[k] !== 1'b0 || err_o[k] !== 1'b0 || rd_o[k] !== 32'h0 || stall_o[k] !== 1'b0) begin
        fails++;
        $display("FAIL reset_values dut%0d: ack=%b err=%b rdata=%h stall=%b want all 0",
                 k, ack_o[k], err_o[k], rd_o[k], stall_o[k]);
      end
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_word();
    run_op(0, 1'b1, 32'h0000_0010, 4'b1111, 32'hDEADBEEF, "word_store");
    run_op(0, 1'b0, 32'h0000_0010, 4'b1111, 32'h0, "word_load");
  endtask

  task automatic test_byte_lanes();
    run_op(0, 1'b1, 32'h0000_0010, 4'b0010, 32'h0000_AA00, "lane_store");
    run_op(0, 1'b0, 32'h0000_0010, 4'b1111, 32'h0, "lane_load_full");
    run_op(0, 1'b0, 32'h0000_0013, 4'b1100, 32'h0, "lane_load_hi");
  endtask

  task automatic test_errors();
    run_op(0, 1'b1, 32'h0000_1000, 4'b1111, 32'h1234_5678, "err_range_store");
    run_op(0, 1'b0, 32'h8000_0000, 4'b1111, 32'h0, "err_range_load");
    run_op(0, 1'b1, 32'h0000_0000, 4'b1111, 32'h0123_4567, "err_prep");
    run_op(0, 1'b1, 32'h0000_0000, 4'b0000, 32'hFFFF_FFFF, "err_nosel");
    run_op(0, 1'b0, 32'h0000_0000, 4'b1111, 32'h0, "err_word0");
  endtask

  task automatic test_back_to_back();
    logic [31:0] d[3];
    logic [31:0] erd;
    logic eer;
    int t[3];
    int cyc, nacks;
    for (int i = 0; i < 3; i++) d[i] = $urandom;
    cyc = 0; nacks = 0;
    @(negedge clk);
    req[0] = 1'b1; we_v[0] = 1'b1; addr_v[0] = 32'h0; sel_v[0] = 4'hF; wd_v[0] = d[0];
    while (nacks < 3 && cyc < 60) begin
      @(posedge clk); cyc++; @(negedge clk);
      checks++;
      if (stall_o[0] !== ~ack_o[0]) begin
        fails++; $display("FAIL b2b_stall cycle %0d: stall=%b ack=%b", cyc, stall_o[0], ack_o[0]);
      end
      if (ack_o[0] === 1'b1) begin
        t[nacks] = cyc;
        model_op(0, 1'b1, addr_v[0], 4'hF, wd_v[0], erd, eer);
        nacks++;
        if (nacks < 3) begin
          addr_v[0] = 32'(4 * nacks); wd_v[0] = d[nacks];
        end else begin
          req[0] = 1'b0;
        end
      end
    end
    req[0] = 1'b0;
    checks++;
    if (nacks != 3) begin
      fails++; $display("FAIL b2b_count: got %0d acks want 3", nacks);
    end else begin
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (t[i] - t[i-1] != wc(0) + 3) begin
          fails++; $display("FAIL b2b_period %0d: got %0d want %0d", i, t[i] - t[i-1], wc(0) + 3);
        end
      end
    end
    for (int i = 0; i < 3; i++) run_op(0, 1'b0, 32'(4 * i), 4'hF, 32'h0, "b2b_readback");
  endtask

  task automatic test_reset_mid_wait();
    run_op(1, 1'b1, 32'h0000_0020, 4'hF, 32'hCAFE_F00D, "rstw_prep");
    run_op(1, 1'b0, 32'h0000_0020, 4'hF, 32'h0, "rstw_prep_load");
    @(negedge clk);
    req[1] = 1'b1; we_v[1] = 1'b1; addr_v[1] = 32'h20; sel_v[1] = 4'hF; wd_v[1] = 32'h0BAD_BEEF;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    for (int k = 0; k < NDUT; k++) begin
      checks++;
      if (ack_o[k] !== 1'b0 || err_o[k] !== 1'b0 || rd_o[k] !== 32'h0 || stall_o[k] !== req[k]) begin
        fails++;
        $display("FAIL rst_async dut%0d: ack=%b err=%b rdata=%h stall=%b want 0 0 0 %b",
                 k, ack_o[k], err_o[k], rd_o[k], stall_o[k], req[k]);
      end
    end
    req[1] = 1'b0;
    #1;
    checks++;
    if (stall_o[1] !== 1'b0) begin
      fails++; $display("FAIL rst_stall_follow: got %b want 0", stall_o[1]);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    run_op(1, 1'b0, 32'h0000_0020, 4'hF, 32'h0, "rstw_nowrite");
  endtask

  task automatic test_sweep();
    for (int k = 2; k < 4; k++) begin
      run_op(k, 1'b1, 32'h0000_0040, 4'hF, $urandom, "sweep_store");
      run_op(k, 1'b1, 32'h0000_0044, 4'b1001, $urandom, "sweep_store2");
      run_op(k, 1'b0, 32'h0000_0040, 4'hF, 32'h0, "sweep_load");
      run_op(k, 1'b0, 32'h0000_0044, 4'b1001, 32'h0, "sweep_load2");
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int k = 0; k < NDUT; k++) begin
      for (int w = 0; w < 16; w++) run_op(k, 1'b1, 32'(4 * w), 4'hF, $urandom, "rand_init");
      for (int n = 0; n < 30; n++) begin
        a = {26'h0, 4'($urandom_range(0, 15)), 2'($urandom)};
        if ($urandom_range(0, 7) == 0) a = a | (32'h1 << $urandom_range(12, 31));
        run_op(k, 1'($urandom), a, 4'($urandom), $urandom, "rand");
      end
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte_lanes();
    test_errors();
    test_back_to_back();
    test_reset_mid_wait();
    test_sweep();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
